// File: rtl/vsweep_pkg.sv
// Shared definitions for the vector sweep sequencer.
//   state_t : sequencer FSM states
//   nvec()  : sweep length for a given UUC input width (2**width)
package vsweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int nvec(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-window counter for one swept vector.
//   clk : clock, state on rising edge
//   rst : synchronous active-high reset
//   clr : return the count to 0
//   inc : count up by one (ignored when clr is high)
//   at  : count has reached SETTLE
// The count never exceeds SETTLE, so it is sized to $clog2(SETTLE+1) bits,
// with a minimum of 1 bit.
module settle_timer #(
  parameter int  SETTLE = 1,
  localparam int CW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CW'(1);
  end

  assign at = (cnt == CW'(SETTLE));

endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweep of a small combinational unit under control (UUC).
// Drives vectors 0..NVEC-1 on uuc_a, holding each SETTLE+1 cycles, samples
// uuc_x on the last edge of each window into result, then compares result
// with the expected table.
//   clk, rst : clock, synchronous active-high reset
//   start    : request a sweep (accepted in IDLE only, abort has priority)
//   abort    : cancel a sweep in progress; partial result is kept
//   expected : expected truth table, bit k for vector k; sampled as the
//              final vector is captured
//   uuc_a    : vector driven to the UUC
//   uuc_x    : UUC output
//   busy     : sweep in progress
//   done     : one-cycle completion pulse
//   pass     : result == expected, valid with done, held until next start
//   result   : captured truth table, bit k = uuc_x seen for vector k
module vector_sweep_ctrl
  import vsweep_pkg::*;
#(
  parameter int  WIDTH  = 4,
  parameter int  SETTLE = 1,
  localparam int NVEC   = nvec(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NVEC-1:0]  expected,
  output logic [WIDTH-1:0] uuc_a,
  input  logic             uuc_x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NVEC-1:0]  result
);

  state_t          state, state_nxt;
  logic            go, cap, quit, last;
  logic            t_clr, t_inc, t_at;
  logic [NVEC-1:0] res_nxt;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (t_clr),
    .inc (t_inc),
    .at  (t_at)
  );

  assign last = (uuc_a == WIDTH'(NVEC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The timer is cleared whenever a vector starts, so in DRIVE t_at is only
  // true when SETTLE==0; that single test covers both the DRIVE-capture and
  // the HOLD-capture cases.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    cap       = 1'b0;
    quit      = 1'b0;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          go        = 1'b1;
          t_clr     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE, HOLD: begin
        if (abort) begin
          quit      = 1'b1;
          t_clr     = 1'b1;
          state_nxt = IDLE;
        end else if (t_at) begin
          cap       = 1'b1;
          t_clr     = 1'b1;
          state_nxt = last ? DONE : DRIVE;
        end else begin
          t_inc     = 1'b1;
          state_nxt = HOLD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result with the current vector's sample merged in; pass is judged on
  // this so it is ready in the same cycle as done.
  always_comb begin
    res_nxt        = result;
    res_nxt[uuc_a] = uuc_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uuc_a  <= '0;
      result <= '0;
      pass   <= 1'b0;
    end else begin
      if (go) begin
        uuc_a  <= '0;
        result <= '0;
        pass   <= 1'b0;
      end
      if (cap) begin
        result <= res_nxt;
        if (last) pass  <= (res_nxt == expected);
        else      uuc_a <= uuc_a + WIDTH'(1);
      end
      if (quit || state == DONE) uuc_a <= '0;
      if (quit) pass <= 1'b0;
    end
  end

  assign busy = (state == DRIVE) || (state == HOLD);
  assign done = (state == DONE);

endmodule
